// File: rtl/uart_pkg.sv
// Shared definitions for the UART host: register map, bit positions and FSM states.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_NOTEMPTY = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_TX_OVF      = 4;
  localparam int ST_RX_STALL    = 5;
  localparam int ST_TX_IDLE     = 6;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_RX_IRQ = 2;
  localparam int CTRL_TX_IRQ = 3;

  localparam int CLR_TX_OVF   = 0;
  localparam int CLR_RX_STALL = 1;
  localparam int CLR_FLUSH    = 2;

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT_DROP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT_DROP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational head view, simultaneous push/pop and flush.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_ONE;
      else if (pop_ok && !push_ok) count_reg <= count_reg - CNT_ONE;
    end
  end

endmodule

// File: rtl/uart_host.sv
// Bus-facing UART host: register file, TX/RX FIFOs and four-phase load/unload FSMs.
module uart_host
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_req,
  input  logic       bus_write,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic       ld_tx_req,
  input  logic       ld_tx_ack,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  input  logic       tx_empty,
  output logic       rx_req,
  input  logic       rx_ack,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  input  logic       rx_empty,
  output logic       irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic       ack_reg, write_reg;
  logic [1:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [3:0] ctrl_reg;
  logic       tx_ovf_reg, rx_stall_reg;
  logic [7:0] tx_data_reg;
  tx_state_t  tx_state_reg, tx_state_next;
  rx_state_t  rx_state_reg, rx_state_next;

  logic          txf_full, txf_empty, rxf_full, rxf_empty;
  logic [7:0]    txf_head, rxf_head;
  logic [CW-1:0] tx_level, rx_level;
  logic          tx_pop, rx_push, rx_stall_set;
  logic          bus_push, bus_pop, clear_wr, flush;
  logic [7:0]    status;
  logic          unused_bits;

  // The UART gates its own loads on tx_empty, so the host never needs it.
  assign unused_bits = ^{tx_empty, wdata_reg[7:4]};

  assign bus_push = ack_reg & write_reg & (addr_reg == ADDR_DATA);
  assign bus_pop  = ack_reg & ~write_reg & (addr_reg == ADDR_DATA) & ~rxf_empty;
  assign clear_wr = ack_reg & write_reg & (addr_reg == ADDR_CLEAR);
  assign flush    = clear_wr & wdata_reg[CLR_FLUSH] &
                    (tx_state_reg == T_IDLE) & (rx_state_reg == R_IDLE);

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) tx_fifo (
    .clk(clk), .reset(reset), .flush(flush),
    .push(bus_push), .push_data(wdata_reg), .pop(tx_pop),
    .head(txf_head), .full(txf_full), .empty(txf_empty), .count(tx_level)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) rx_fifo (
    .clk(clk), .reset(reset), .flush(flush),
    .push(rx_push), .push_data(rx_data), .pop(bus_pop),
    .head(rxf_head), .full(rxf_full), .empty(rxf_empty), .count(rx_level)
  );

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      T_IDLE: if (ctrl_reg[CTRL_TX_EN] && !txf_empty && !ld_tx_ack) begin
        tx_state_next = T_REQ;
        tx_pop        = 1'b1;
      end
      T_REQ:       if (ld_tx_ack)  tx_state_next = T_WAIT_DROP;
      T_WAIT_DROP: if (!ld_tx_ack) tx_state_next = T_IDLE;
      default:     tx_state_next = T_IDLE;
    endcase
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_push       = 1'b0;
    rx_stall_set  = 1'b0;
    case (rx_state_reg)
      R_IDLE: if (!rx_empty && ctrl_reg[CTRL_RX_EN]) begin
        if (rxf_full) rx_stall_set  = 1'b1;
        else          rx_state_next = R_REQ;
      end
      R_REQ: if (rx_ack) begin
        rx_push       = 1'b1;
        rx_state_next = R_WAIT_DROP;
      end
      R_WAIT_DROP: if (!rx_ack) rx_state_next = R_IDLE;
      default:     rx_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    status                 = '0;
    status[ST_TX_FULL]     = txf_full;
    status[ST_TX_EMPTY]    = txf_empty;
    status[ST_RX_NOTEMPTY] = (rx_level != '0);
    status[ST_RX_FULL]     = rxf_full;
    status[ST_TX_OVF]      = tx_ovf_reg;
    status[ST_RX_STALL]    = rx_stall_reg;
    status[ST_TX_IDLE]     = (tx_state_reg == T_IDLE);
  end

  // Read data is driven only during the ack cycle; the RX pop lands at its end.
  always_comb begin
    bus_rdata = 8'h00;
    if (ack_reg && !write_reg) begin
      case (addr_reg)
        ADDR_DATA:   bus_rdata = rxf_empty ? 8'h00 : rxf_head;
        ADDR_STATUS: bus_rdata = status;
        ADDR_CTRL:   bus_rdata = {4'h0, ctrl_reg};
        default:     bus_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg      <= 1'b0;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      ctrl_reg     <= '0;
      tx_ovf_reg   <= 1'b0;
      rx_stall_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_state_reg <= T_IDLE;
      rx_state_reg <= R_IDLE;
    end else begin
      ack_reg      <= bus_req;
      write_reg    <= bus_write;
      addr_reg     <= bus_addr;
      wdata_reg    <= bus_wdata;
      tx_state_reg <= tx_state_next;
      rx_state_reg <= rx_state_next;
      if (tx_pop) tx_data_reg <= txf_head;
      if (ack_reg && write_reg && addr_reg == ADDR_CTRL) ctrl_reg <= wdata_reg[3:0];
      if (clear_wr && wdata_reg[CLR_TX_OVF]) tx_ovf_reg <= 1'b0;
      else if (bus_push && txf_full)         tx_ovf_reg <= 1'b1;
      if (rx_stall_set)                         rx_stall_reg <= 1'b1;
      else if (clear_wr && wdata_reg[CLR_RX_STALL]) rx_stall_reg <= 1'b0;
    end
  end

  assign bus_ack   = ack_reg;
  assign tx_data   = tx_data_reg;
  assign ld_tx_req = (tx_state_reg == T_REQ);
  assign rx_req    = (rx_state_reg == R_REQ);
  assign tx_enable = ctrl_reg[CTRL_TX_EN];
  assign rx_enable = ctrl_reg[CTRL_RX_EN];
  assign irq       = (ctrl_reg[CTRL_RX_IRQ] & (rx_level != '0)) |
                     (ctrl_reg[CTRL_TX_IRQ] & (tx_level == '0));

endmodule
